// File: rtl/router_input_ctrl.sv
// Router input-port controller: latches the lookahead route from the header flit,
// requests the output port, then streams the packet from the FIFO into the crossbar.
//
// state | meaning
// IDLE  | waiting for a head flit; malformed heads are popped and flagged
// REQ   | route latched, requesting the output port until granted
// XFER  | granted, forwarding flits until the tail/single flit transfers
module router_input_ctrl #(
  parameter int Width    = 66,
  parameter int NumPorts = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fifo_empty,
  input  logic [Width-1:0]    fifo_data,
  output logic                fifo_rdreq,
  output logic [NumPorts-1:0] out_req,
  input  logic [NumPorts-1:0] out_grant,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [Width-1:0]    out_data,
  output logic                out_last,
  output logic                err_flit
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } state_e;

  localparam logic [NumPorts-1:0] RouteOne = {{(NumPorts-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [NumPorts-1:0] route_q, route_d;

  logic [1:0]          flit_type;
  logic [NumPorts-1:0] head_route;
  logic                is_head;
  logic                is_last;
  logic                route_onehot;

  assign flit_type    = fifo_data[Width-1:Width-2];
  assign head_route   = fifo_data[NumPorts-1:0];
  assign is_head      = flit_type[1];
  assign is_last      = flit_type[0];
  assign route_onehot = (head_route != '0) && ((head_route & (head_route - RouteOne)) == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      route_q <= '0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    route_d    = route_q;
    out_req    = '0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_last   = 1'b0;
    fifo_rdreq = 1'b0;
    err_flit   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          if (is_head && route_onehot) begin
            route_d = head_route;
            state_d = REQ;
          end else begin
            fifo_rdreq = 1'b1;
            err_flit   = 1'b1;
          end
        end
      end
      REQ: begin
        out_req = route_q;
        if ((out_grant & route_q) != '0) begin
          state_d = XFER;
        end
      end
      XFER: begin
        // Grant is not re-checked here; the allocator holds it while out_req is up.
        out_req    = route_q;
        out_valid  = ~fifo_empty;
        out_data   = fifo_data;
        out_last   = ~fifo_empty & is_last;
        fifo_rdreq = ~fifo_empty & out_ready;
        if (fifo_rdreq && out_last) begin
          state_d = IDLE;
          route_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        route_d = '0;
      end
    endcase

    // Outputs are forced quiet while reset is held so nothing is popped or requested.
    if (rst) begin
      out_req    = '0;
      out_valid  = 1'b0;
      out_data   = '0;
      out_last   = 1'b0;
      fifo_rdreq = 1'b0;
      err_flit   = 1'b0;
    end
  end

  a_req_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(out_req));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) fifo_rdreq |-> !fifo_empty);
  a_valid_in_xfer: assert property (@(posedge clk) disable iff (rst) out_valid |-> (state_q == XFER));

endmodule

// File: tb/tb_router_input_ctrl.sv
// Directed bench for router_input_ctrl: a queue models the upstream FIFO and each
// step compares the controller outputs with hand-derived values.
module tb_router_input_ctrl;

  localparam int W = 66;
  localparam int P = 5;

  logic         clk;
  logic         rst;
  logic         fifo_empty;
  logic [W-1:0] fifo_data;
  logic         fifo_rdreq;
  logic [P-1:0] out_req;
  logic [P-1:0] out_grant;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         err_flit;

  int checks   = 0;
  int failures = 0;
  int npops    = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] sent[$];

  router_input_ctrl #(.Width(W), .NumPorts(P)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rdreq (fifo_rdreq),
    .out_req    (out_req),
    .out_grant  (out_grant),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .err_flit   (err_flit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkr(input string tag, input logic [P-1:0] obs, input logic [P-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic update_fifo();
    fifo_empty = (q.size() == 0);
    fifo_data  = fifo_empty ? '0 : q[0];
  endtask

  // Advance one clock; a pop requested before the edge removes the head after it.
  task automatic tick();
    logic p;
    logic v;
    logic [W-1:0] dummy;
    p = fifo_rdreq;
    v = out_valid;
    @(posedge clk);
    #1;
    if (p && q.size() > 0) begin
      if (v) sent.push_back(q[0]);
      dummy = q.pop_front();
      npops++;
    end
    update_fifo();
  endtask

  task automatic set(input logic [P-1:0] g, input logic r);
    out_grant = g;
    out_ready = r;
    #1;
  endtask

  function automatic logic [W-1:0] fl(input logic [1:0] t, input logic [58:0] pay,
                                      input logic [P-1:0] rt);
    return {t, pay, rt};
  endfunction

  logic [W-1:0] h1, b1, t1, s2, h3, b3a, b3b, t3, h4, b4, t4, b5, h5, h6, b6, t6;
  logic         rdy_seq [7];
  logic [W-1:0] head_seq[7];
  logic         last_seq[7];
  int           pops0;

  initial begin
    h1  = fl(2'b10, 59'h111, 5'b00100);
    b1  = {2'b00, 64'hA5};
    t1  = fl(2'b01, 59'h1F1, 5'b01010);
    s2  = fl(2'b11, 59'h222, 5'b10000);
    h3  = fl(2'b10, 59'h333, 5'b00001);
    b3a = fl(2'b00, 59'h3A0, 5'b11111);
    b3b = fl(2'b00, 59'h3B0, 5'b00000);
    t3  = fl(2'b01, 59'h3F0, 5'b10101);
    h4  = fl(2'b10, 59'h444, 5'b01000);
    b4  = fl(2'b00, 59'h4B0, 5'b00110);
    t4  = fl(2'b01, 59'h4F0, 5'b00000);
    b5  = fl(2'b00, 59'h555, 5'b00100);
    h5  = fl(2'b10, 59'h5A5, 5'b00011);
    h6  = fl(2'b10, 59'h666, 5'b00010);
    b6  = fl(2'b00, 59'h6B0, 5'b00001);
    t6  = fl(2'b01, 59'h6F0, 5'b01000);

    // Reset state with a header already waiting at the FIFO head.
    rst = 1'b1;
    out_grant = '0;
    out_ready = 1'b0;
    q.push_back(h1); q.push_back(b1); q.push_back(t1);
    update_fifo();
    #2;
    chkr("rst_out_req", out_req, 5'b00000);
    chk1("rst_rdreq", fifo_rdreq, 1'b0);
    chk1("rst_valid", out_valid, 1'b0);
    chk1("rst_err", err_flit, 1'b0);
    chk1("rst_last", out_last, 1'b0);
    tick();
    rst = 1'b0;

    // 3-flit packet, grant at first request, out_ready=1.
    sent.delete();
    set(5'b00100, 1'b1);
    chkr("p1_c0_req", out_req, 5'b00000);
    chk1("p1_c0_rdreq", fifo_rdreq, 1'b0);
    chk1("p1_c0_err", err_flit, 1'b0);
    tick(); set(5'b00100, 1'b1);
    chkr("p1_c1_req", out_req, 5'b00100);
    chk1("p1_c1_valid", out_valid, 1'b0);
    chk1("p1_c1_rdreq", fifo_rdreq, 1'b0);
    tick(); set(5'b00100, 1'b1);
    chk1("p1_c2_valid", out_valid, 1'b1);
    chkw("p1_c2_data", out_data, h1);
    chk1("p1_c2_last", out_last, 1'b0);
    chk1("p1_c2_rdreq", fifo_rdreq, 1'b1);
    tick(); set(5'b00100, 1'b1);
    chkw("p1_c3_data", out_data, b1);
    chk1("p1_c3_last", out_last, 1'b0);
    tick(); set(5'b00100, 1'b1);
    chkw("p1_c4_data", out_data, t1);
    chk1("p1_c4_last", out_last, 1'b1);
    chk1("p1_c4_rdreq", fifo_rdreq, 1'b1);
    tick(); set(5'b00100, 1'b1);
    chkr("p1_c5_req", out_req, 5'b00000);
    chk1("p1_c5_valid", out_valid, 1'b0);
    chkw("p1_sent_cnt", W'(sent.size()), W'(3));

    // Single flit, grant withheld (then non-overlapping) before arriving.
    sent.delete();
    q.push_back(s2);
    update_fifo();
    set(5'b00000, 1'b1);
    chkr("p2_idle_req", out_req, 5'b00000);
    chk1("p2_idle_rdreq", fifo_rdreq, 1'b0);
    tick(); set(5'b00000, 1'b1);
    chkr("p2_r1_req", out_req, 5'b10000);
    chk1("p2_r1_valid", out_valid, 1'b0);
    tick(); set(5'b00001, 1'b1);
    chkr("p2_r2_req", out_req, 5'b10000);
    chk1("p2_r2_valid", out_valid, 1'b0);
    tick(); set(5'b10000, 1'b1);
    chkr("p2_r3_req", out_req, 5'b10000);
    chk1("p2_r3_valid", out_valid, 1'b0);
    chk1("p2_r3_rdreq", fifo_rdreq, 1'b0);
    tick(); set(5'b10000, 1'b1);
    chk1("p2_x_valid", out_valid, 1'b1);
    chkw("p2_x_data", out_data, s2);
    chk1("p2_x_last", out_last, 1'b1);
    chk1("p2_x_rdreq", fifo_rdreq, 1'b1);
    tick(); set(5'b10000, 1'b1);
    chkr("p2_idle2_req", out_req, 5'b00000);
    chk1("p2_idle2_valid", out_valid, 1'b0);

    // Backpressure: out_ready 1,0,0,1,1,0,1 across a 4-flit packet.
    sent.delete();
    q.push_back(h3); q.push_back(b3a); q.push_back(b3b); q.push_back(t3);
    update_fifo();
    rdy_seq  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    head_seq = '{h3, b3a, b3a, b3a, b3b, t3, t3};
    last_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    set(5'b00001, 1'b1);
    tick(); set(5'b00001, 1'b1);
    chkr("p3_req", out_req, 5'b00001);
    tick();
    for (int i = 0; i < 7; i++) begin
      set(5'b00001, rdy_seq[i]);
      chk1($sformatf("p3_valid_%0d", i), out_valid, 1'b1);
      chkw($sformatf("p3_data_%0d", i), out_data, head_seq[i]);
      chk1($sformatf("p3_rdreq_%0d", i), fifo_rdreq, rdy_seq[i]);
      chk1($sformatf("p3_last_%0d", i), out_last, last_seq[i]);
      chkr($sformatf("p3_req_%0d", i), out_req, 5'b00001);
      tick();
    end
    set(5'b00001, 1'b1);
    chkr("p3_end_req", out_req, 5'b00000);
    chkw("p3_sent_cnt", W'(sent.size()), W'(4));
    chkw("p3_sent0", sent[0], h3);
    chkw("p3_sent1", sent[1], b3a);
    chkw("p3_sent2", sent[2], b3b);
    chkw("p3_sent3", sent[3], t3);

    // Starvation: tail arrives 5 cycles late; grant withdrawn meanwhile is ignored.
    sent.delete();
    q.push_back(h4); q.push_back(b4);
    update_fifo();
    set(5'b01000, 1'b1);
    tick(); set(5'b01000, 1'b1);
    chkr("p4_req", out_req, 5'b01000);
    tick(); set(5'b01000, 1'b1);
    chkw("p4_h_data", out_data, h4);
    tick(); set(5'b01000, 1'b1);
    chkw("p4_b_data", out_data, b4);
    chk1("p4_b_last", out_last, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      set(5'b00000, 1'b1);
      chk1($sformatf("p4_gap_valid_%0d", i), out_valid, 1'b0);
      chkr($sformatf("p4_gap_req_%0d", i), out_req, 5'b01000);
      chk1($sformatf("p4_gap_rdreq_%0d", i), fifo_rdreq, 1'b0);
      tick();
    end
    q.push_back(t4);
    update_fifo();
    set(5'b00000, 1'b1);
    chk1("p4_t_valid", out_valid, 1'b1);
    chkw("p4_t_data", out_data, t4);
    chk1("p4_t_last", out_last, 1'b1);
    chk1("p4_t_rdreq", fifo_rdreq, 1'b1);
    tick(); set(5'b00000, 1'b1);
    chkr("p4_end_req", out_req, 5'b00000);
    chkw("p4_sent_cnt", W'(sent.size()), W'(3));

    // Malformed heads: body flit, then header with multi-hot route.
    pops0 = npops;
    q.push_back(b5); q.push_back(h5);
    update_fifo();
    set(5'b11111, 1'b1);
    chk1("p5_b_err", err_flit, 1'b1);
    chk1("p5_b_rdreq", fifo_rdreq, 1'b1);
    chkr("p5_b_req", out_req, 5'b00000);
    tick(); set(5'b11111, 1'b1);
    chk1("p5_h_err", err_flit, 1'b1);
    chk1("p5_h_rdreq", fifo_rdreq, 1'b1);
    chkr("p5_h_req", out_req, 5'b00000);
    tick(); set(5'b11111, 1'b1);
    chk1("p5_e_err", err_flit, 1'b0);
    chk1("p5_e_rdreq", fifo_rdreq, 1'b0);
    chkr("p5_e_req", out_req, 5'b00000);
    chkw("p5_pops", W'(npops - pops0), W'(2));
    tick(); set(5'b11111, 1'b1);
    chkr("p5_e2_req", out_req, 5'b00000);

    // Asynchronous reset between body and tail, then the orphan tail is dropped.
    q.push_back(h6); q.push_back(b6); q.push_back(t6);
    update_fifo();
    set(5'b00010, 1'b1);
    tick(); set(5'b00010, 1'b1);
    tick(); set(5'b00010, 1'b1);
    chkw("p6_h_data", out_data, h6);
    tick(); set(5'b00010, 1'b1);
    chkw("p6_b_data", out_data, b6);
    tick(); set(5'b00010, 1'b1);
    chkw("p6_t_data", out_data, t6);
    chk1("p6_t_last", out_last, 1'b1);
    rst = 1'b1;
    #1;
    chkr("p6_rst_req", out_req, 5'b00000);
    chk1("p6_rst_valid", out_valid, 1'b0);
    chk1("p6_rst_rdreq", fifo_rdreq, 1'b0);
    tick(); set(5'b00010, 1'b1);
    chk1("p6_rst2_valid", out_valid, 1'b0);
    rst = 1'b0;
    pops0 = npops;
    #1;
    chk1("p6_rel_err", err_flit, 1'b1);
    chk1("p6_rel_rdreq", fifo_rdreq, 1'b1);
    chkr("p6_rel_req", out_req, 5'b00000);
    chk1("p6_rel_valid", out_valid, 1'b0);
    tick(); set(5'b00010, 1'b1);
    chk1("p6_end_err", err_flit, 1'b0);
    chkw("p6_pops", W'(npops - pops0), W'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
